load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 44 ++++
 rtl/load_store_unit_load_align.sv | 33 +++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states,
// the default bus timeout and the access legality/alignment rule.
package load_store_unit_pkg;

  localparam int DEFAULT_ACK_TIMEOUT = 15;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsuState_e;

  // Illegal width codes are reported through the same path as misalignment.
  function automatic logic accessOk(input logic isStore, input logic [2:0] f3,
                                    input logic [1:0] addrLsb);
    logic ok;
    ok = 1'b0;
    if (isStore) begin
      case (f3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~addrLsb[0];
        F3_SW:   ok = (addrLsb == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~addrLsb[0];
        F3_LW:         ok = (addrLsb == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load formatter: picks the addressed byte/half lane out of the
// bus word and sign- or zero-extends it according to funct3.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addrLsb_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] result_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    case (addrLsb_i)
      2'd0:    laneByte = rdata_i[7:0];
      2'd1:    laneByte = rdata_i[15:8];
      2'd2:    laneByte = rdata_i[23:16];
      default: laneByte = rdata_i[31:24];
    endcase
    laneHalf = addrLsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (f3_i)
      F3_LB:   result_o = {{24{laneByte[7]}}, laneByte};
      F3_LH:   result_o = {{16{laneHalf[15]}}, laneHalf};
      F3_LBU:  result_o = {24'b0, laneByte};
      F3_LHU:  result_o = {16'b0, laneHalf};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: forwards ALU results to writeback when idle, otherwise runs
// one bus transaction at a time with a bounded wait for mem_ack.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] d_add,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [2:0]  f3,
  input  logic [4:0]  alu_rd,
  input  logic        alu_reg_w_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_w_en,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CntW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  lsuState_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          memReq_q, memReq_d, memWe_q, memWe_d;
  logic [31:0]   memAddr_q, memAddr_d, memWdata_q, memWdata_d;
  logic [3:0]    memBe_q, memBe_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    addrLsb_q, addrLsb_d;
  logic [4:0]    rd_q, rd_d, wbRd_q, wbRd_d;
  logic [31:0]   wbData_q, wbData_d;
  logic          wbWEn_q, wbWEn_d, misalign_q, misalign_d, busErr_q, busErr_d;
  logic [31:0]   storeData, loadResult;
  logic [3:0]    storeBe;

  load_align uLoadAlign (
    .rdata_i   (mem_rdata),
    .addrLsb_i (addrLsb_q),
    .f3_i      (f3_q),
    .result_o  (loadResult)
  );

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        storeData = {4{alu_out[7:0]}};
        storeBe   = 4'b0001 << d_add[1:0];
      end
      2'b01: begin
        storeData = {2{alu_out[15:0]}};
        storeBe   = 4'b0011 << d_add[1:0];
      end
      default: begin
        storeData = alu_out;
        storeBe   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memBe_d    = memBe_q;
    f3_d       = f3_q;
    addrLsb_d  = addrLsb_q;
    rd_d       = rd_q;
    wbData_d   = wbData_q;
    wbRd_d     = wbRd_q;
    wbWEn_d    = 1'b0;
    misalign_d = 1'b0;
    busErr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_w_en || d_r_en) begin
          // d_w_en wins when both enables are high.
          if (accessOk(d_w_en, f3, d_add[1:0])) begin
            state_d    = BUSY;
            cnt_d      = '0;
            memReq_d   = 1'b1;
            memWe_d    = d_w_en;
            memAddr_d  = {d_add[31:2], 2'b00};
            memWdata_d = d_w_en ? storeData : memWdata_q;
            memBe_d    = d_w_en ? storeBe : 4'b1111;
            f3_d       = f3;
            addrLsb_d  = d_add[1:0];
            rd_d       = alu_rd;
          end else begin
            misalign_d = 1'b1;
          end
        end else begin
          wbData_d = alu_out;
          wbRd_d   = alu_rd;
          wbWEn_d  = alu_reg_w_en;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d  = IDLE;
          cnt_d    = '0;
          memReq_d = 1'b0;
          if (!memWe_q) begin
            wbData_d = loadResult;
            wbRd_d   = rd_q;
            wbWEn_d  = 1'b1;
          end
        end else if (cnt_q == CntLast) begin
          state_d  = IDLE;
          cnt_d    = '0;
          memReq_d = 1'b0;
          busErr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memBe_q    <= '0;
      f3_q       <= '0;
      addrLsb_q  <= '0;
      rd_q       <= '0;
      wbData_q   <= '0;
      wbRd_q     <= '0;
      wbWEn_q    <= 1'b0;
      misalign_q <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memBe_q    <= memBe_d;
      f3_q       <= f3_d;
      addrLsb_q  <= addrLsb_d;
      rd_q       <= rd_d;
      wbData_q   <= wbData_d;
      wbRd_q     <= wbRd_d;
      wbWEn_q    <= wbWEn_d;
      misalign_q <= misalign_d;
      busErr_q   <= busErr_d;
    end
  end

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_be    = memBe_q;
  assign wb_data   = wbData_q;
  assign wb_rd     = wbRd_q;
  assign wb_w_en   = wbWEn_q;
  assign misalign  = misalign_q;
  assign bus_err   = busErr_q;
  assign stall     = (state_q == BUSY);

endmodule
